// File: rtl/lvdc_backplane_if.sv
// lvdc_backplane_if: bus and status bundle of the LVDC backplane.
//   irq      - asynchronous interrupt request (rising-edge sensitive)
//   booted   - high once the ROM image has been copied into low RAM
//   mem_addr - current shared-bus address
//   mem_val  - current shared-bus data (read data, or write data on a store)
// The master modport is the backplane side; the slave modport is the observer/driver side.
interface lvdc_backplane_if;
  logic        irq;
  logic        booted;
  logic [14:0] mem_addr;
  logic [25:0] mem_val;

  modport master (
    input  irq,
    output booted,
    output mem_addr,
    output mem_val
  );

  modport slave (
    output irq,
    input  booted,
    input  mem_addr,
    input  mem_val
  );
endinterface

// File: rtl/lvdc_backplane.sv
// lvdc_backplane: boot sequencer, program ROM, 32K-word RAM and a two-phase accumulator CPU
// sharing one memory bus.
//   clk - system clock, all state on the rising edge
//   rst - synchronous active-high reset
//   bus - lvdc_backplane_if.master (irq in; booted, mem_addr, mem_val out)
// After reset the ROM is copied word-by-word into RAM[0..ROM_WORDS-1], then the CPU runs
// from address 0. Each instruction takes FETCH + EXEC; a taken interrupt adds one cycle.
// Build option: define LVDC_IRQ_EN to include the interrupt synchronizer, pending flag,
// epc/ie and the EI/DI/RTI opcodes. Without it irq is ignored and A/B/C execute as NOP.
module lvdc_backplane #(
  parameter int unsigned ROM_WORDS  = 2048,
  parameter logic [14:0] IRQ_VECTOR = 15'h0010
) (
  input logic              clk,
  input logic              rst,
  lvdc_backplane_if.master bus
);
  localparam int unsigned KW = $clog2(ROM_WORDS);
  localparam logic [KW-1:0] KLast = KW'(ROM_WORDS - 1);

  localparam logic [3:0] OpCla = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpSto = 4'h5;
  localparam logic [3:0] OpTra = 4'h6;
  localparam logic [3:0] OpTmi = 4'h7;
  localparam logic [3:0] OpTnz = 4'h8;
  localparam logic [3:0] OpShr = 4'h9;
  localparam logic [3:0] OpHlt = 4'hD;
`ifdef LVDC_IRQ_EN
  localparam logic [3:0] OpEi  = 4'hA;
  localparam logic [3:0] OpDi  = 4'hB;
  localparam logic [3:0] OpRti = 4'hC;
`endif

  typedef enum logic [1:0] {StBoot, StFetch, StExec, StHalt} state_e;

  // ROM contents are loaded from outside the design (image preload).
  logic [25:0] rom [ROM_WORDS];
  logic [25:0] ram [32768];

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          booted_q, booted_d;
  logic [14:0]   pc_q, pc_d;
  logic [25:0]   acc_q, acc_d;
  logic          halted_q, halted_d;
  logic [3:0]    op_q, op_d;
  logic [14:0]   addr_q, addr_d;

  logic          ram_we;
  logic [14:0]   ram_waddr;
  logic [25:0]   ram_wdata;
  logic [25:0]   fetch_word;
  logic [25:0]   operand;
  logic [14:0]   mem_addr;
  logic [25:0]   mem_val;
  logic          take_irq;

  assign fetch_word = ram[pc_q];
  assign operand    = ram[addr_q];

`ifdef LVDC_IRQ_EN
  logic [14:0] epc_q, epc_d;
  logic        ie_q, ie_d;
  logic        pending_q, pending_d;
  logic [2:0]  irq_sync_q;
  logic        irq_rise;

  // Two flops resynchronize irq, the third holds the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) irq_sync_q <= '0;
    else     irq_sync_q <= {irq_sync_q[1:0], bus.irq};
  end

  assign irq_rise = irq_sync_q[1] & ~irq_sync_q[2];
  // Instruction boundaries are FETCH entry and the HALT wait.
  assign take_irq = pending_q & ie_q & ((state_q == StFetch) | (state_q == StHalt));
  // A new edge in the same cycle as a take stays pending.
  assign pending_d = (pending_q & ~take_irq) | (irq_rise & booted_q);
`else
  logic unused_irq;
  assign unused_irq = bus.irq;
  assign take_irq   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    booted_d  = booted_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    halted_d  = halted_q;
    op_d      = op_q;
    addr_d    = addr_q;
    ram_we    = 1'b0;
    ram_waddr = addr_q;
    ram_wdata = acc_q;
    mem_addr  = pc_q;
    mem_val   = fetch_word;
`ifdef LVDC_IRQ_EN
    epc_d     = epc_q;
    ie_d      = ie_q;
`endif

    unique case (state_q)
      StBoot: begin
        mem_addr  = 15'(k_q);
        mem_val   = rom[k_q];
        ram_we    = 1'b1;
        ram_waddr = 15'(k_q);
        ram_wdata = rom[k_q];
        k_d       = k_q + 1'b1;
        if (k_q == KLast) begin
          booted_d = 1'b1;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        op_d    = fetch_word[25:22];
        addr_d  = fetch_word[14:0];
        pc_d    = pc_q + 15'd1;
        state_d = StExec;
      end
      StExec: begin
        mem_addr = addr_q;
        mem_val  = operand;
        state_d  = StFetch;
        case (op_q)
          OpCla: acc_d = operand;
          OpAdd: acc_d = acc_q + operand;
          OpSub: acc_d = acc_q - operand;
          OpAnd: acc_d = acc_q & operand;
          OpSto: begin
            ram_we  = 1'b1;
            mem_val = acc_q;
          end
          OpTra: pc_d = addr_q;
          OpTmi: if (acc_q[25]) pc_d = addr_q;
          OpTnz: if (acc_q != '0) pc_d = addr_q;
          OpShr: acc_d = {acc_q[25], acc_q[25:1]};
          OpHlt: begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
`ifdef LVDC_IRQ_EN
          OpEi:  ie_d = 1'b1;
          OpDi:  ie_d = 1'b0;
          OpRti: begin
            pc_d = epc_q;
            ie_d = 1'b1;
          end
`endif
          default: ;
        endcase
      end
      StHalt: ;
    endcase

    // Taken interrupt replaces the boundary cycle; FETCH then proceeds at the vector.
    if (take_irq) begin
      op_d     = op_q;
      addr_d   = addr_q;
      pc_d     = IRQ_VECTOR;
      halted_d = 1'b0;
      state_d  = StFetch;
`ifdef LVDC_IRQ_EN
      epc_d    = pc_q;
      ie_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StBoot;
      k_q      <= '0;
      booted_q <= 1'b0;
      pc_q     <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
      op_q     <= '0;
      addr_q   <= '0;
`ifdef LVDC_IRQ_EN
      epc_q     <= '0;
      ie_q      <= 1'b0;
      pending_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      booted_q <= booted_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      halted_q <= halted_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
`ifdef LVDC_IRQ_EN
      epc_q     <= epc_d;
      ie_q      <= ie_d;
      pending_q <= pending_d;
`endif
    end
  end

  // RAM is never cleared; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (ram_we && !rst) ram[ram_waddr] <= ram_wdata;
  end

  assign bus.booted   = booted_q;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_val  = mem_val;

endmodule

// File: tb/tb_lvdc_backplane.sv
module tb_lvdc_backplane;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lvdc_backplane_if bus ();

  lvdc_backplane dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rom_fill_index();
    for (int i = 0; i < 2048; i++) dut.rom[i] = 26'(i);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 2048; i++) dut.rom[i] = 26'h0;
  endtask

  // Reset, release, and run through the full 2048-cycle copy.
  task automatic boot();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2048);
  endtask

  initial begin
    int bad;
    bit found;
    bus.irq = 1'b0;

    // ---------------- reset state and boot copy ----------------
    rom_fill_index();
    dut.rom[0] = 26'h0000000;
    rst = 1'b1;
    step(2);
    check("rst_booted", 32'(bus.booted), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_val", 32'(bus.mem_val), 32'd0);
    check("rst_pc", 32'(dut.pc_q), 32'd0);
    check("rst_acc", 32'(dut.acc_q), 32'd0);
    check("rst_halted", 32'(dut.halted_q), 32'd0);
    rst = 1'b0;
    step(500);
    check("boot_addr_500", 32'(bus.mem_addr), 32'd500);
    check("boot_val_500", 32'(bus.mem_val), 32'd500);
    bus.irq = 1'b1;               // edge during boot must be discarded
    step(4);
    bus.irq = 1'b0;
    step(1543);                   // 2047 edges since release
    check("boot_addr_2047", 32'(bus.mem_addr), 32'd2047);
    check("boot_not_done", 32'(bus.booted), 32'd0);
    step(1);
    check("boot_done", 32'(bus.booted), 32'd1);
    check("first_fetch_addr", 32'(bus.mem_addr), 32'd0);
    bad = 0;
    for (int i = 0; i < 2048; i++) if (dut.ram[i] !== 26'(i)) bad++;
    check("ram_image_bad_words", 32'(bad), 32'd0);
`ifdef LVDC_IRQ_EN
    check("boot_irq_dropped", 32'(dut.pending_q), 32'd0);
`endif

    // ---------------- reset in the middle of boot ----------------
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1000);
    check("midboot_addr", 32'(bus.mem_addr), 32'd1000);
    rst = 1'b1;
    step(1);
    check("midboot_rst_booted", 32'(bus.booted), 32'd0);
    check("midboot_rst_addr", 32'(bus.mem_addr), 32'd0);
    rst = 1'b0;
    step(2047);
    check("reboot_not_done", 32'(bus.booted), 32'd0);
    step(1);
    check("reboot_done", 32'(bus.booted), 32'd1);

    // ---------------- arithmetic: CLA/ADD/STO/HLT ----------------
    rom_clear();
    dut.rom[0]   = 26'h0400064;   // CLA 100
    dut.rom[1]   = 26'h0800065;   // ADD 101
    dut.rom[2]   = 26'h1400066;   // STO 102
    dut.rom[3]   = 26'h3400000;   // HLT
    dut.rom[100] = 26'h0000005;
    dut.rom[101] = 26'h3FFFFFF;
    boot();
    step(7);
    check("arith_not_halted", 32'(dut.halted_q), 32'd0);
    step(1);
    check("arith_halted", 32'(dut.halted_q), 32'd1);
    check("arith_ram102", 32'(dut.ram[102]), 32'h4);
    check("arith_acc", 32'(dut.acc_q), 32'h4);
    check("arith_pc", 32'(dut.pc_q), 32'h4);

    // ---------------- branches: TMI taken, TNZ not taken ----------------
    rom_clear();
    dut.rom[0]    = 26'h0400040;  // CLA 0x40
    dut.rom[1]    = 26'h1C00020;  // TMI 0x20
    dut.rom[2]    = 26'h3400000;  // HLT (wrong path)
    dut.rom[32]   = 26'h0400041;  // CLA 0x41
    dut.rom[33]   = 26'h2000030;  // TNZ 0x30
    dut.rom[34]   = 26'h3400000;  // HLT
    dut.rom[48]   = 26'h3400000;  // HLT (wrong path)
    dut.rom[64]   = 26'h2000000;
    dut.rom[65]   = 26'h0000000;
    boot();
    step(4);
    check("tmi_pc", 32'(dut.pc_q), 32'h20);
    step(6);
    check("tnz_halted", 32'(dut.halted_q), 32'd1);
    check("tnz_pc", 32'(dut.pc_q), 32'h23);
    check("tnz_acc", 32'(dut.acc_q), 32'h0);

`ifdef LVDC_IRQ_EN
    // ---------------- interrupt entry and RTI ----------------
    rom_clear();
    dut.rom[0]  = 26'h2800000;    // EI
    dut.rom[5]  = 26'h1800005;    // TRA 5
    dut.rom[16] = 26'h0400040;    // CLA 0x40
    dut.rom[17] = 26'h1400041;    // STO 0x41
    dut.rom[18] = 26'h3000000;    // RTI
    dut.rom[64] = 26'h0000123;
    boot();
    step(20);
    bus.irq = 1'b1;
    step(2);
    bus.irq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step(1);
      if (dut.pc_q == 15'h10) found = 1'b1;
    end
    check("irq_vector_reached", 32'(found), 32'd1);
    check("irq_epc", 32'(dut.epc_q), 32'd5);
    check("irq_ie_cleared", 32'(dut.ie_q), 32'd0);
    step(6);
    check("rti_pc", 32'(dut.pc_q), 32'd5);
    check("rti_ie", 32'(dut.ie_q), 32'd1);
    check("isr_store", 32'(dut.ram[65]), 32'h123);

    // ---------------- masked after DI, taken after EI ----------------
    rom_clear();
    dut.rom[0]  = 26'h2C00000;    // DI
    dut.rom[12] = 26'h2800000;    // EI
    dut.rom[13] = 26'h180000D;    // TRA 13
    dut.rom[16] = 26'h3400000;    // HLT
    boot();
    bus.irq = 1'b1;
    step(2);
    bus.irq = 1'b0;
    step(12);
    check("masked_pending", 32'(dut.pending_q), 32'd1);
    check("masked_pc", 32'(dut.pc_q), 32'd7);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (dut.halted_q) found = 1'b1;
    end
    check("unmasked_taken", 32'(found), 32'd1);
    check("unmasked_epc", 32'(dut.epc_q), 32'd13);
    check("unmasked_pc", 32'(dut.pc_q), 32'h11);
`else
    // ---------------- irq ignored, EI is a NOP ----------------
    rom_clear();
    dut.rom[0]  = 26'h2800000;    // EI (NOP here)
    dut.rom[1]  = 26'h1800001;    // TRA 1
    dut.rom[16] = 26'h3400000;    // HLT
    boot();
    bus.irq = 1'b1;
    step(4);
    bus.irq = 1'b0;
    step(30);
    check("irq_ignored_halted", 32'(dut.halted_q), 32'd0);
    check("irq_ignored_pc", 32'((dut.pc_q == 15'd1) || (dut.pc_q == 15'd2)), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
